// File: rtl/freq_gen.sv
// freq_gen: slow/medium/fast display clocks divided from CLOCK, plus a glitch-free CURRCLK picked by SW0..SW2.
// Latency: each source toggles every DIV cycles; CURRCLK lags its source by 1; request visible 2 cycles after a pin change.
// Backpressure: none; a source change waits for the old-source fall, then the target fall; requests during a change are ignored.
// Optional FREQ_GEN_DEBOUNCE_EN: each switch must stay stable DEBOUNCE_CYCLES cycles before it reaches the request.
module freq_gen #(
    parameter int SLOW_DIV        = 50_000_000,
    parameter int MED_DIV         = 12_500_000,
    parameter int FAST_DIV        = 3_125_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    output logic       SLOWCLK,
    output logic       MEDCLK,
    output logic       FASTCLK,
    output logic       CURRCLK,
    output logic [1:0] SEL,
    output logic       SWITCHING
);
    localparam logic [1:0] SRC_SLOW = 2'b00;
    localparam logic [1:0] SRC_MED  = 2'b01;
    localparam logic [1:0] SRC_FAST = 2'b10;

    typedef enum logic [1:0] {RUN, DRAIN, PARK} state_t;

    logic [2:0] src;
    logic [2:0] src_q;
    logic [2:0] fall;
    logic [2:0] sw_s1;
    logic [2:0] sw_s2;
    logic [2:0] sw_req;
    logic [1:0] req;
    logic [1:0] target;
    logic [1:0] target_nxt;
    logic [1:0] sel_nxt;
    logic       curr_nxt;
    state_t     state;
    state_t     state_nxt;

    if (SLOW_DIV < 1 || MED_DIV < 1 || FAST_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("freq_gen: divider and debounce parameters must be >= 1");
    end

    // Bit index of src matches the SEL encoding: 0 slow, 1 medium, 2 fast.
    for (genvar g = 0; g < 3; g++) begin : g_div
        localparam int DIV = (g == 0) ? SLOW_DIV : (g == 1) ? MED_DIV : FAST_DIV;
        localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
        logic [CW-1:0] cnt;
        logic          tog;

        always_ff @(posedge CLOCK) begin
            if (RESET) begin
                cnt <= '0;
                tog <= 1'b0;
            end else if (cnt == CW'(DIV - 1)) begin
                cnt <= '0;
                tog <= ~tog;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        assign src[g] = tog;
    end

    assign SLOWCLK = src[0];
    assign MEDCLK  = src[1];
    assign FASTCLK = src[2];
    assign fall    = src_q & ~src;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            src_q <= '0;
        end else begin
            sw_s1 <= {SW2, SW1, SW0};
            sw_s2 <= sw_s1;
            src_q <= src;
        end
    end

`ifdef FREQ_GEN_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          deb;

        always_ff @(posedge CLOCK) begin
            if (RESET) begin
                cnt <= '0;
                deb <= 1'b0;
            end else if (sw_s2[g] == deb) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                deb <= sw_s2[g];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end

        assign sw_req[g] = deb;
    end
`else
    assign sw_req = sw_s2;
`endif

    function automatic logic pick(input logic [2:0] v, input logic [1:0] s);
        case (s)
            SRC_SLOW: return v[0];
            SRC_MED:  return v[1];
            SRC_FAST: return v[2];
            default:  return 1'b0;
        endcase
    endfunction

    always_comb begin
        req = SRC_MED;
        if (sw_req[2])      req = SRC_FAST;
        else if (sw_req[1]) req = SRC_MED;
        else if (sw_req[0]) req = SRC_SLOW;
    end

    // CURRCLK only ever follows SEL's source or sits low in PARK, so every phase is whole.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = SEL;
        target_nxt = target;
        curr_nxt   = pick(src, SEL);
        case (state)
            RUN: begin
                if (req != SEL) begin
                    target_nxt = req;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (pick(fall, SEL)) state_nxt = PARK;
            end
            PARK: begin
                curr_nxt = 1'b0;
                if (pick(fall, target)) begin
                    sel_nxt   = target;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= RUN;
            SEL     <= SRC_MED;
            target  <= SRC_MED;
            CURRCLK <= 1'b0;
        end else begin
            state   <= state_nxt;
            SEL     <= sel_nxt;
            target  <= target_nxt;
            CURRCLK <= curr_nxt;
        end
    end

    assign SWITCHING = (state != RUN);

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen with SLOW_DIV=8, MED_DIV=4, FAST_DIV=2, DEBOUNCE_CYCLES=16.
// A cycle model queues the expected outputs after every edge; a switch-pattern table and hand sequences cover the corner cases.
module tb_freq_gen;
    localparam int SD = 8;
    localparam int MD = 4;
    localparam int FD = 2;
    localparam int DC = 16;
`ifdef FREQ_GEN_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw0 = 1'b0;
    logic       sw1 = 1'b0;
    logic       sw2 = 1'b0;
    logic       slowclk, medclk, fastclk, currclk, switching;
    logic [1:0] sel;

    always #5 clk = ~clk;

    freq_gen #(
        .SLOW_DIV(SD), .MED_DIV(MD), .FAST_DIV(FD), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLOCK(clk), .RESET(rst), .SW0(sw0), .SW1(sw1), .SW2(sw2),
        .SLOWCLK(slowclk), .MEDCLK(medclk), .FASTCLK(fastclk),
        .CURRCLK(currclk), .SEL(sel), .SWITCHING(switching)
    );

    typedef struct packed {
        logic       slow;
        logic       med;
        logic       fast;
        logic       curr;
        logic [1:0] sel;
        logic       sw;
    } obs_t;

    typedef struct {
        logic [2:0] sw;
        int         cycles;
        logic [1:0] want_sel;
        logic       want_switch;
    } vec_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: n counts edges since reset release; mode 0 run, 1 drain, 2 park.
    int         n;
    logic [2:0] s1, s2, deb;
    int         run_len[3];
    int         mode;
    logic [1:0] msel, mtgt;
    logic       mcurr;

    // CURRCLK phase tracker
    logic pval;
    int   plen;
    bit   pvalid = 1'b0;

    function automatic logic srcval(int cnt, int div);
        return ((cnt / div) % 2) == 1;
    endfunction

    function automatic logic fell(int cnt, int div);
        return (cnt > 0) && (cnt % div == 0) && ((cnt / div) % 2 == 0);
    endfunction

    function automatic int divof(logic [1:0] s);
        return (s == 2'd0) ? SD : (s == 2'd1) ? MD : FD;
    endfunction

    task automatic model_edge();
        logic [2:0] rq;
        logic [1:0] req;
        if (rst) begin
            n = 0; s1 = '0; s2 = '0; deb = '0;
            run_len = '{default: 0};
            mode = 0; msel = 2'd1; mtgt = 2'd1; mcurr = 1'b0;
        end else begin
            rq  = DEB ? deb : s2;
            req = rq[2] ? 2'd2 : rq[1] ? 2'd1 : rq[0] ? 2'd0 : 2'd1;
            case (mode)
                0: begin
                    mcurr = srcval(n, divof(msel));
                    if (req != msel) begin mtgt = req; mode = 1; end
                end
                1: begin
                    mcurr = srcval(n, divof(msel));
                    if (fell(n, divof(msel))) mode = 2;
                end
                default: begin
                    mcurr = 1'b0;
                    if (fell(n, divof(mtgt))) begin msel = mtgt; mode = 0; end
                end
            endcase
            if (DEB) begin
                for (int i = 0; i < 3; i++) begin
                    if (s2[i] == deb[i]) run_len[i] = 0;
                    else begin
                        run_len[i]++;
                        if (run_len[i] == DC) begin deb[i] = s2[i]; run_len[i] = 0; end
                    end
                end
            end
            s2 = s1;
            s1 = {sw2, sw1, sw0};
            n++;
        end
    endtask

    task automatic tick();
        obs_t a, e;
        @(posedge clk);
        model_edge();
        exp_q.push_back({srcval(n, SD), srcval(n, MD), srcval(n, FD), mcurr, msel, (mode != 0)});
        @(negedge clk);
        a = {slowclk, medclk, fastclk, currclk, sel, switching};
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL cycle t=%0t slow,med,fast,curr,sel,switching got=%b want=%b", $time, a, e);
        end
        if (rst) begin
            pvalid = 1'b0; pval = a.curr; plen = 1;
        end else if (a.curr === pval) begin
            plen++;
        end else begin
            if (pvalid) begin
                checks++;
                if (pval ? !(plen inside {SD, MD, FD}) : (plen < FD)) begin
                    failures++;
                    $display("FAIL phase t=%0t level=%b got_len=%0d want %s", $time, pval, plen,
                             pval ? "exactly one DIV" : ">= 2");
                end
            end
            pvalid = 1'b1; pval = a.curr; plen = 1;
        end
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_switching(string name, logic level, int limit);
        int i = 0;
        while (switching !== level && i < limit) begin tick(); i++; end
        checks++;
        if (switching !== level) begin
            failures++;
            $display("FAIL %s timeout: switching=%b want=%b after %0d cycles", name, switching, level, i);
        end
    endtask

    task automatic wait_mode(string name, int m, int limit);
        int i = 0;
        while (mode != m && i < limit) begin tick(); i++; end
        checks++;
        if (mode != m) begin
            failures++;
            $display("FAIL %s timeout: model state %0d never reached %0d (sel=%0d)", name, mode, m, sel);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic seen;
        logic saw_fast;
        int   k;

        vecs[0] = '{3'b000, 60, 2'd1, 1'b1};
        vecs[1] = '{3'b011, 40, 2'd1, 1'b0};
        vecs[2] = '{3'b001, 60, 2'd0, 1'b1};
        vecs[3] = '{3'b010, 60, 2'd1, 1'b1};
        vecs[4] = '{3'b100, 60, 2'd2, 1'b1};
        vecs[5] = '{3'b111, 40, 2'd2, 1'b0};
        vecs[6] = '{3'b001, 60, 2'd0, 1'b1};

        // Reset state and phase alignment
        rst = 1'b1;
        tick(); tick();
        chk("rst_sel", sel, 1);
        chk("rst_switching", switching, 0);
        chk("rst_curr", currclk, 0);
        chk("rst_sources", {slowclk, medclk, fastclk}, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("med_before_rise", medclk, 0);
        tick();
        chk("med_rise_at_4", medclk, 1);
        chk("curr_lags_med", currclk, 0);
        tick();
        chk("curr_rise_at_5", currclk, 1);
        repeat (20) tick();
        chk("steady_med_sel", sel, 1);

        // Pin edge to SWITCHING latency, then complete switch to fast
        sw2 = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (switching) begin k = i; break; end
        end
        chk("switch_latency", k, DEB ? 19 : 3);
        wait_switching("to_fast_done", 1'b0, 60);
        chk("sel_fast", sel, 2);

        // Switch-pattern table
        for (int v = 0; v < 7; v++) begin
            {sw2, sw1, sw0} = vecs[v].sw;
            seen = 1'b0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                if (switching) seen = 1'b1;
            end
            chk($sformatf("vec%0d_sel", v), sel, vecs[v].want_sel);
            chk($sformatf("vec%0d_switch_seen", v), seen, vecs[v].want_switch);
        end

        // Request changed while parked: finish at fast, then move on to slow
        {sw2, sw1, sw0} = 3'b010;
        repeat (25) tick();
        wait_switching("to_med_idle", 1'b0, 60);
        chk("park_pre_sel", sel, 1);
        {sw2, sw1, sw0} = 3'b100;
        wait_mode("reach_park", 2, 60);
        {sw2, sw1, sw0} = 3'b001;
        wait_switching("park_first_done", 1'b0, 40);
        chk("park_first_sel", sel, 2);
        wait_switching("park_second_start", 1'b1, 40);
        wait_switching("park_second_done", 1'b0, 60);
        chk("park_second_sel", sel, 0);

        // Reset pulse during PARK abandons the switch
        {sw2, sw1, sw0} = 3'b010;
        repeat (25) tick();
        wait_switching("to_med_idle2", 1'b0, 60);
        {sw2, sw1, sw0} = 3'b100;
        wait_mode("reach_park2", 2, 60);
        rst = 1'b1;
        {sw2, sw1, sw0} = 3'b000;
        tick();
        rst = 1'b0;
        chk("park_rst_sel", sel, 1);
        chk("park_rst_curr", currclk, 0);
        chk("park_rst_switching", switching, 0);
        chk("park_rst_sources", {slowclk, medclk, fastclk}, 0);
        repeat (30) tick();
        chk("post_rst_sel", sel, 1);

        // 5-cycle SW2 glitch
        seen = 1'b0;
        saw_fast = 1'b0;
        sw2 = 1'b1;
        for (int c = 0; c < 75; c++) begin
            if (c == 5) sw2 = 1'b0;
            tick();
            if (switching) seen = 1'b1;
            if (sel == 2'd2) saw_fast = 1'b1;
        end
        chk("glitch_switch_seen", seen, DEB ? 0 : 1);
        chk("glitch_reached_fast", saw_fast, DEB ? 0 : 1);
        chk("glitch_final_sel", sel, 1);
        chk("glitch_final_switching", switching, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
